// File: rtl/apb_alu_slave.sv
// apb_alu_slave: APB ALU slave (ADD/SUB/ABSDIFF, optional MUL when APB_ALU_MUL_EN is defined)
module apb_alu_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PRWADDR,
    input  logic [DATA_W-1:0] PRWDATA,
    output logic [DATA_W-1:0] PRDATA1,
    output logic              PREADY,
    output logic              PSLVERR
);
    typedef enum logic [1:0] {IDLE, CALC, DONE_ST} state_t;
    state_t state, state_nx;
    logic [3:0] wcnt;
    logic [DATA_W-1:0] a, b, result, rd_val, alu_res, d_ab, d_ba, sub_res, abs_res;
    logic [DATA_W:0] sum;
    logic [1:0] op;
    logic [2:0] idx;
    logic done, ovf, busy, alu_ovf, calc_end, ge;
    logic mapped, op3_bad, err, commit, wr, start, res_rd;

    assign idx     = PRWADDR[4:2];
    assign mapped  = PRWADDR[ADDR_W-1:5] == '0 && PRWADDR[1:0] == 2'b00 && idx <= 3'd4;
    assign busy    = state == CALC;
    assign PREADY  = PSEL & PENABLE & (wcnt == 4'd0);
    assign err     = !mapped | (PWRITE & (idx >= 3'd3 | busy | (idx == 3'd2 & op3_bad)));
    assign PSLVERR = PREADY & err;
    assign commit  = PREADY & !err;
    assign wr      = commit & PWRITE;
    assign start   = wr & (idx == 3'd2) & PRWDATA[2];
    assign res_rd  = commit & !PWRITE & (idx == 3'd4);
    assign rd_val  = idx == 3'd0 ? a :
                     idx == 3'd1 ? b :
                     idx == 3'd2 ? {{(DATA_W-2){1'b0}}, op} :
                     idx == 3'd3 ? {{(DATA_W-3){1'b0}}, ovf, done, busy} : result;
    assign PRDATA1 = commit ? rd_val : '0;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign d_ab    = a - b;
    assign d_ba    = b - a;
    assign ge      = a >= b;
    assign sub_res = ge ? d_ab : {1'b1, d_ba[DATA_W-2:0]};
    assign abs_res = ge ? d_ab : d_ba;

`ifdef APB_ALU_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    logic [2*DATA_W-1:0] mc, acc, acc_nx;
    logic [DATA_W-1:0] mp;
    logic [CNT_W-1:0] mcnt;
    assign op3_bad  = 1'b0;
    assign acc_nx   = acc + (mp[0] ? mc : '0);
    assign calc_end = op != 2'd3 || mcnt == '0;
    assign alu_res  = op == 2'd0 ? sum[DATA_W-1:0] : op == 2'd1 ? sub_res :
                      op == 2'd2 ? abs_res : acc_nx[DATA_W-1:0];
    assign alu_ovf  = op == 2'd0 ? sum[DATA_W] : (op == 2'd3) & (|acc_nx[2*DATA_W-1:DATA_W]);
    // Shift-add multiplier: one partial product accumulated per CALC cycle
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            mc   <= '0;
            acc  <= '0;
            mp   <= '0;
            mcnt <= '0;
        end else if (start) begin
            mc   <= {{DATA_W{1'b0}}, a};
            acc  <= '0;
            mp   <= b;
            mcnt <= CNT_W'(DATA_W - 1);
        end else if (busy && op == 2'd3) begin
            acc  <= acc_nx;
            mc   <= mc << 1;
            mp   <= mp >> 1;
            mcnt <= mcnt - 1'b1;
        end
    end
`else
    assign op3_bad  = PRWDATA[1:0] == 2'd3;
    assign calc_end = 1'b1;
    assign alu_res  = op == 2'd0 ? sum[DATA_W-1:0] : op == 2'd1 ? sub_res : abs_res;
    assign alu_ovf  = (op == 2'd0) & sum[DATA_W];
`endif

    // Wait-state counter: loaded in setup, counts down through the access phase
    always_ff @(posedge PCLK) begin
        if (PRESET)
            wcnt <= 4'd0;
        else if (PSEL && !PENABLE)
            wcnt <= 4'(WAIT_STATES);
        else if (PSEL && PENABLE && wcnt != 4'd0)
            wcnt <= wcnt - 4'd1;
    end

    // Register file, result capture and sticky DONE (a new START beats DONE set)
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            a      <= '0;
            b      <= '0;
            op     <= '0;
            result <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (wr && idx == 3'd0) a <= PRWDATA;
            if (wr && idx == 3'd1) b <= PRWDATA;
            if (wr && idx == 3'd2) op <= PRWDATA[1:0];
            if (busy && calc_end) begin
                result <= alu_res;
                ovf    <= alu_ovf;
            end
            done <= start ? 1'b0 : (busy && calc_end) ? 1'b1 : res_rd ? 1'b0 : done;
        end
    end

    // Compute FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Compute FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CALC : IDLE;
            CALC:    state_nx = calc_end ? DONE_ST : CALC;
            DONE_ST: state_nx = start ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_apb_alu_slave.sv
// tb_apb_alu_slave: directed table-driven bench for apb_alu_slave with 3 wait states
module tb_apb_alu_slave;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PRWADDR = '0;
    logic [31:0] PRWDATA = '0;
    logic [31:0] PRDATA1;
    logic        PREADY;
    logic        PSLVERR;
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        string       nm;
    } vec_t;
    vec_t vt[$];

    apb_alu_slave #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(3)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRDATA1(PRDATA1), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void add(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, input logic er, input string nm);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wd = wd; v.rd = rd; v.er = er; v.nm = nm;
        vt.push_back(v);
    endfunction

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int nw);
        nw = 0;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PRWADDR = addr; PRWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        while (!PREADY && nw < 40) begin
            nw++;
            @(negedge PCLK);
            #1;
        end
        if (!PREADY) chk("pready_timeout", 32'(PREADY), 32'd1);
        rd = PRDATA1;
        er = PSLVERR;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr_chk(input logic [31:0] addr, input logic [31:0] wd, input logic er_exp, input string nm);
        logic [31:0] rd; logic er; int nw;
        apb(1'b1, addr, wd, rd, er, nw);
        chk(nm, 32'(er), 32'(er_exp));
    endtask

    task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        logic [31:0] rd; logic er; int nw;
        apb(1'b0, addr, 32'h0, rd, er, nw);
        chk(nm, rd, exp);
        chk({nm, "_err"}, 32'(er), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int nw;
        logic got_done;

        add(0, 32'h00, 0, 32'h0, 0, "rst_a");
        add(0, 32'h04, 0, 32'h0, 0, "rst_b");
        add(0, 32'h08, 0, 32'h0, 0, "rst_ctrl");
        add(0, 32'h0C, 0, 32'h0, 0, "rst_status");
        add(0, 32'h10, 0, 32'h0, 0, "rst_result");
        add(1, 32'h00, 32'd7, 0, 0, "wr_a7");
        add(1, 32'h04, 32'd5, 0, 0, "wr_b5");
        add(1, 32'h08, 32'h5, 0, 0, "start_sub");
        add(0, 32'h0C, 0, 32'h2, 0, "sub_status_done");
        add(0, 32'h10, 0, 32'h2, 0, "sub_7_5");
        add(0, 32'h0C, 0, 32'h0, 0, "done_cleared");
        add(0, 32'h08, 0, 32'h1, 0, "ctrl_start_reads0");
        add(1, 32'h00, 32'd5, 0, 0, "wr_a5");
        add(1, 32'h04, 32'd7, 0, 0, "wr_b7");
        add(1, 32'h08, 32'h5, 0, 0, "start_sub2");
        add(0, 32'h10, 0, 32'h80000002, 0, "sub_5_7");
        add(1, 32'h00, 32'hFFFFFFFF, 0, 0, "wr_a_max");
        add(1, 32'h04, 32'd2, 0, 0, "wr_b2");
        add(1, 32'h08, 32'h4, 0, 0, "start_add");
        add(0, 32'h0C, 0, 32'h6, 0, "add_status_ovf");
        add(0, 32'h10, 0, 32'h1, 0, "add_wrap");
        add(0, 32'h0C, 0, 32'h4, 0, "add_done_clr");
        add(1, 32'h00, 32'd3, 0, 0, "wr_a3");
        add(1, 32'h04, 32'd10, 0, 0, "wr_b10");
        add(1, 32'h08, 32'h6, 0, 0, "start_absdiff");
        add(0, 32'h10, 0, 32'h7, 0, "absdiff_3_10");
        add(0, 32'h0C, 0, 32'h0, 0, "absdiff_status");
        add(0, 32'h14, 0, 32'h0, 1, "rd_unmapped14");
        add(0, 32'h100, 0, 32'h0, 1, "rd_upper_bits");
        add(1, 32'h0C, 32'h7, 0, 1, "wr_status_ro");
        add(1, 32'h10, 32'h55, 0, 1, "wr_result_ro");
        add(0, 32'h00, 0, 32'h3, 0, "a_kept");
        add(0, 32'h10, 0, 32'h7, 0, "result_kept");

        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_prdata", PRDATA1, 32'h0);
        PRESET = 1'b0;

        foreach (vt[i]) begin
            apb(vt[i].wr, vt[i].addr, vt[i].wd, rd, er, nw);
            chk({vt[i].nm, "_err"}, 32'(er), 32'(vt[i].er));
            chk({vt[i].nm, "_waits"}, 32'(nw), 32'd3);
            if (!vt[i].wr) chk(vt[i].nm, rd, vt[i].rd);
        end

`ifdef APB_ALU_MUL_EN
        wr_chk(32'h00, 32'h10000, 1'b0, "mul_wr_a");
        wr_chk(32'h04, 32'h10000, 1'b0, "mul_wr_b");
        wr_chk(32'h08, 32'h7, 1'b0, "mul_start");
        wr_chk(32'h00, 32'h55, 1'b1, "mul_wr_a_busy");
        rd_chk(32'h00, 32'h10000, "mul_a_unchanged");
        wr_chk(32'h08, 32'h7, 1'b1, "mul_start_busy");
        rd_chk(32'h0C, 32'h1, "mul_status_busy");
        got_done = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            apb(1'b0, 32'h0C, 32'h0, rd, er, nw);
            got_done = rd[1];
        end
        chk("mul_done_poll", 32'(got_done), 32'd1);
        rd_chk(32'h0C, 32'h6, "mul_status_ovf");
        rd_chk(32'h10, 32'h0, "mul_result");
`else
        wr_chk(32'h08, 32'h3, 1'b1, "op3_rejected");
        wr_chk(32'h08, 32'h7, 1'b1, "op3_start_rejected");
        rd_chk(32'h08, 32'h2, "ctrl_unchanged");
        rd_chk(32'h0C, 32'h0, "op3_not_started");
`endif

`ifdef APB_ALU_MUL_EN
        wr_chk(32'h08, 32'h7, 1'b0, "midrst_start");
`else
        wr_chk(32'h08, 32'h4, 1'b0, "midrst_start");
`endif
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        rd_chk(32'h0C, 32'h0, "midrst_status");
        rd_chk(32'h10, 32'h0, "midrst_result");
        rd_chk(32'h00, 32'h0, "midrst_a");
        wr_chk(32'h00, 32'd7, 1'b0, "post_wr_a");
        wr_chk(32'h04, 32'd5, 1'b0, "post_wr_b");
        wr_chk(32'h08, 32'h4, 1'b0, "post_start");
        rd_chk(32'h0C, 32'h2, "post_status");
        rd_chk(32'h10, 32'd12, "post_result");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
